// File: rtl/matrix_scan_if.sv
// matrix_scan_if: board-state inputs and LED matrix pins of the Tetris display scanner
interface matrix_scan_if;
    logic [127:0] map;
    logic [2:0]   x1, x2, x3, x4;
    logic [3:0]   y1, y2, y3, y4;
    logic         stop;
    logic [15:0]  dot_row;
    logic [7:0]   dot_col;
    logic         frame_start;

    modport master (
        output map, x1, x2, x3, x4, y1, y2, y3, y4, stop,
        input  dot_row, dot_col, frame_start
    );

    modport slave (
        input  map, x1, x2, x3, x4, y1, y2, y3, y4, stop,
        output dot_row, dot_col, frame_start
    );
endinterface

// File: rtl/matrix_scan.sv
// matrix_scan: merges settled map with falling block and row-scans an 8x16 LED matrix, blinking on game over.
// Optional feature: define SCAN_BLANK_EN to insert one blank cycle after each row's HOLD cycles.
module matrix_scan #(
    parameter int HOLD      = 1,
    parameter int BLINK_DIV = 5000
) (
    input logic          clk_10000Hz,
    input logic          reset,
    matrix_scan_if.slave bus
);
    localparam int HW = $clog2(HOLD + 2);
    localparam int BW = $clog2(BLINK_DIV + 1);
`ifdef SCAN_BLANK_EN
    localparam logic [HW-1:0] LAST = HW'(HOLD);
`else
    localparam logic [HW-1:0] LAST = HW'(HOLD - 1);
`endif

    logic [3:0]    r_row_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic [127:0]  r_frame_buf;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic [15:0]   r_dot_row;
    logic [7:0]    r_dot_col;
    logic          r_frame_start;

    logic [127:0]  w_comp;
    logic          w_latch;
    logic          w_lit;
    logic [7:0]    w_row_bits;

    // {y,x} is exactly y*8+x, so each falling cell maps straight onto its map bit
    assign w_comp = bus.map
                  | (128'd1 << {bus.y1, bus.x1})
                  | (128'd1 << {bus.y2, bus.x2})
                  | (128'd1 << {bus.y3, bus.x3})
                  | (128'd1 << {bus.y4, bus.x4});

    assign w_latch = (r_row_cnt == 4'd0) && (r_hold_cnt == '0);
`ifdef SCAN_BLANK_EN
    assign w_lit = (r_hold_cnt != LAST);
`else
    assign w_lit = 1'b1;
`endif
    // Row 0 of the new frame comes straight from the composite since frame_buf loads this same edge
    assign w_row_bits = w_latch ? w_comp[7:0] : r_frame_buf[{r_row_cnt, 3'b000} +: 8];

    // Row/hold scan counters, frame latch and registered pin drive
    always_ff @(posedge clk_10000Hz or negedge reset) begin
        if (!reset) begin
            r_row_cnt     <= 4'd0;
            r_hold_cnt    <= '0;
            r_frame_buf   <= '0;
            r_dot_row     <= 16'h0000;
            r_dot_col     <= 8'hFF;
            r_frame_start <= 1'b0;
        end else begin
            if (r_hold_cnt == LAST) begin
                r_hold_cnt <= '0;
                r_row_cnt  <= r_row_cnt + 4'd1;
            end else begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end
            if (w_latch)
                r_frame_buf <= w_comp;
            r_frame_start <= w_latch;
            r_dot_row     <= w_lit ? (16'd1 << r_row_cnt) : 16'h0000;
            r_dot_col     <= (w_lit && r_blink_on) ? ~w_row_bits : 8'hFF;
        end
    end

    // Game-over blink: half-period of BLINK_DIV cycles, held lit while stop is low
    always_ff @(posedge clk_10000Hz or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (!bus.stop) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    assign bus.dot_row     = r_dot_row;
    assign bus.dot_col     = r_dot_col;
    assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan: randomized directed steps checked against a cycle-count reference model of the scanner
module tb_matrix_scan;
    localparam int HOLD = 2;
    localparam int BD   = 4;
`ifdef SCAN_BLANK_EN
    localparam int PER = HOLD + 1;
`else
    localparam int PER = HOLD;
`endif
    localparam int FP = 16 * PER;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_scan_if bus();
    matrix_scan #(.HOLD(HOLD), .BLINK_DIV(BD)) dut (
        .clk_10000Hz(clk),
        .reset(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int t = 0;
    int n = 0;
    logic mblink = 1'b1;
    logic [127:0] mframe = '0;
    logic [15:0] er;
    logic [7:0] ec;
    logic ef;

    task automatic check(input string tag);
        total++;
        assert (bus.dot_row === er) else begin
            bad++;
            $error("FAIL %s dot_row t=%0d: observed %h expected %h", tag, t, bus.dot_row, er);
        end
        total++;
        assert (bus.dot_col === ec) else begin
            bad++;
            $error("FAIL %s dot_col t=%0d: observed %h expected %h", tag, t, bus.dot_col, ec);
        end
        total++;
        assert (bus.frame_start === ef) else begin
            bad++;
            $error("FAIL %s frame_start t=%0d: observed %b expected %b", tag, t, bus.frame_start, ef);
        end
    endtask

    task automatic model_reset();
        t = 0;
        n = 0;
        mblink = 1'b1;
        er = 16'h0000;
        ec = 8'hFF;
        ef = 1'b0;
    endtask

    // One clock edge: predict pins from elapsed cycles since reset release, then compare
    task automatic cycle(input string tag);
        logic [127:0] c;
        int row, slot;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            c = bus.map;
            c[bus.y1 * 8 + bus.x1] = 1'b1;
            c[bus.y2 * 8 + bus.x2] = 1'b1;
            c[bus.y3 * 8 + bus.x3] = 1'b1;
            c[bus.y4 * 8 + bus.x4] = 1'b1;
            ef = (t % FP) == 0;
            if (ef)
                mframe = c;
            row = (t / PER) % 16;
            slot = t % PER;
            er = (slot < HOLD) ? (16'd1 << row) : 16'h0000;
            ec = (slot < HOLD && mblink) ? ~mframe[row * 8 +: 8] : 8'hFF;
            if (bus.stop) begin
                n++;
                mblink = ((n / BD) % 2) == 0;
            end else begin
                n = 0;
                mblink = 1'b1;
            end
            t++;
        end
        #1 check(tag);
    endtask

    task automatic rand_in(input bit with_stop);
        bus.map = {$urandom, $urandom, $urandom, $urandom};
        bus.x1 = 3'($urandom_range(0, 7)); bus.y1 = 4'($urandom_range(0, 15));
        bus.x2 = 3'($urandom_range(0, 7)); bus.y2 = 4'($urandom_range(0, 15));
        bus.x3 = 3'($urandom_range(0, 7)); bus.y3 = 4'($urandom_range(0, 15));
        bus.x4 = 3'($urandom_range(0, 7)); bus.y4 = 4'($urandom_range(0, 15));
        if (with_stop)
            bus.stop = 1'($urandom_range(0, 1));
    endtask

    initial begin
        model_reset();
        bus.stop = 1'b0;
        rand_in(1'b1);
        // held in reset while inputs toggle
        for (int i = 0; i < 6; i++) begin
            cycle("in_reset");
            rand_in(1'b1);
        end
        // horizontal bar on row 0 over an empty map
        bus.map = '0;
        bus.stop = 1'b0;
        bus.x1 = 3'd2; bus.x2 = 3'd3; bus.x3 = 3'd4; bus.x4 = 3'd5;
        bus.y1 = 4'd0; bus.y2 = 4'd0; bus.y3 = 4'd0; bus.y4 = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FP; i++)
            cycle("bar");
        // bottom-right corner settled
        bus.map[127] = 1'b1;
        for (int i = 0; i < FP + 2; i++)
            cycle("corner");
        // row 5 filled while mid-frame
        while ((t % FP) != 5 * PER)
            cycle("to_row5");
        bus.map[47:40] = 8'hFF;
        for (int i = 0; i < FP + 2 * PER; i++)
            cycle("row5_fill");
        // random board changes each cycle
        for (int i = 0; i < 3 * FP; i++) begin
            cycle("random");
            rand_in(1'b0);
        end
        // sustained game over, then restore
        bus.stop = 1'b1;
        for (int i = 0; i < 5 * BD + 3; i++)
            cycle("blink");
        bus.stop = 1'b0;
        for (int i = 0; i < 4; i++)
            cycle("unblink");
        // random stop toggling
        for (int i = 0; i < 2 * FP; i++) begin
            cycle("rand_stop");
            if ($urandom_range(0, 7) == 0)
                rand_in(1'b1);
            else if ($urandom_range(0, 9) == 0)
                bus.stop = ~bus.stop;
        end
        // asynchronous reset at row 9
        bus.stop = 1'b0;
        while ((t % FP) != 9 * PER)
            cycle("to_row9");
        #3 rst_n = 1'b0;
        model_reset();
        #1 check("async_rst");
        cycle("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FP; i++) begin
            cycle("after_rst");
            if (i % 5 == 0)
                rand_in(1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
